// File: rtl/stack_controller_pkg.sv
// stack_controller_pkg: op codes, FSM states and default sizing shared by the stack controller and its bench.
package stack_controller_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 16;
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_POP2 = 2'b10,
    OP_PEEK = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD1,
    S_CAP1,
    S_CAP2,
    S_RESP,
    S_ERR
  } state_e;
  function automatic logic op_err(input op_e op, input logic is_empty, input logic is_full,
                                  input logic below_two);
    return (op == OP_PUSH) ? is_full : (op == OP_POP2) ? below_two : is_empty;
  endfunction
endpackage

// File: rtl/stack_ram.sv
// stack_ram: single-port stack storage, synchronous write and synchronous read, no reset.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/stack_controller.sv
// stack_controller: handshaked, error-checked operand stack sequencer over a sync-read RAM.
// Define STACK_WATERMARK_EN to add the peak-occupancy watermark output.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_a,
  output logic [DATA_W-1:0] resp_b,
`ifdef STACK_WATERMARK_EN
  output logic [PTR_W:0]    watermark,
`endif
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);
  localparam logic [PTR_W:0] ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] TWO = (PTR_W + 1)'(2);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d, ra_q, ra_d, rb_q, rb_d, ram_rdata;
  logic [PTR_W:0] sp_q, sp_d, sp_m1, sp_m2;
  logic full_q, empty_q, accept, err_in, ram_we;
  logic [PTR_W-1:0] ram_addr;
  assign req_ready = (state_q == S_IDLE) && !clear;
  assign accept = req_valid && req_ready;
  assign err_in = op_err(op_e'(req_op), empty_q, full_q, sp_q < TWO);
  assign sp_m1 = sp_q - ONE;
  assign sp_m2 = sp_q - TWO;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    data_d = data_q;
    ra_d = ra_q;
    rb_d = rb_q;
    sp_d = sp_q;
    ram_we = 1'b0;
    ram_addr = sp_q[PTR_W-1:0];
    case (state_q)
      S_IDLE: begin
        if (clear) sp_d = '0;
        else if (accept) begin
          op_d = op_e'(req_op);
          data_d = req_data;
          rb_d = (req_op == OP_POP2 && !err_in) ? rb_q : '0;
          ra_d = err_in ? '0 : ra_q;
          state_d = err_in ? S_ERR : (req_op == OP_PUSH) ? S_WRITE : S_RD1;
        end
      end
      S_WRITE: begin
        ram_we = 1'b1;
        sp_d = sp_q + ONE;
        state_d = S_RESP;
      end
      S_RD1: begin
        ram_addr = sp_m1[PTR_W-1:0];
        state_d = S_CAP1;
      end
      S_CAP1: begin
        ra_d = ram_rdata;
        ram_addr = sp_m2[PTR_W-1:0];
        sp_d = (op_q == OP_POP) ? sp_m1 : sp_q;
        state_d = (op_q == OP_POP2) ? S_CAP2 : S_RESP;
      end
      S_CAP2: begin
        rb_d = ram_rdata;
        sp_d = sp_m2;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q <= OP_PUSH;
      data_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      sp_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      data_q <= data_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      sp_q <= sp_d;
      full_q <= sp_d == FULL_CNT;
      empty_q <= sp_d == '0;
    end
  end
`ifdef STACK_WATERMARK_EN
  logic [PTR_W:0] wm_q, wm_d;
  always_comb wm_d = (state_q == S_IDLE && clear) ? '0 : (sp_d > wm_q) ? sp_d : wm_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wm_q <= '0;
    else wm_q <= wm_d;
  end
  assign watermark = wm_q;
`endif
  assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign resp_err = state_q == S_ERR;
  assign resp_a = ra_q;
  assign resp_b = rb_q;
  assign count = sp_q;
  assign full = full_q;
  assign empty = empty_q;
  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data_q),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: directed self-checking bench for stack_controller (DATA_W=8, DEPTH=16).
module tb_stack_controller;
  import stack_controller_pkg::*;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = '0;
  logic req_ready, resp_valid, resp_err, full, empty;
  logic [7:0] resp_a, resp_b;
  logic [4:0] count;
`ifdef STACK_WATERMARK_EN
  logic [4:0] watermark;
`endif
  int n_chk = 0, n_fail = 0;
  stack_controller #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_a(resp_a), .resp_b(resp_b),
`ifdef STACK_WATERMARK_EN
    .watermark(watermark),
`endif
    .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xact(input string tag, input op_e op, input logic [7:0] d, input int lat,
                      input logic err, input int a, input int b, input int cnt);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 10);
    check({tag, "_lat"}, n, lat);
    check({tag, "_err"}, resp_err, err);
    if (a >= 0) check({tag, "_a"}, resp_a, a);
    check({tag, "_b"}, resp_b, b);
    check({tag, "_cnt"}, count, cnt);
    @(negedge clk);
    check({tag, "_pulse"}, resp_valid, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", req_ready, 1);
    check("rst_rvalid", resp_valid, 0);
    check("rst_rerr", resp_err, 0);
    check("rst_a", resp_a, 0);
    check("rst_b", resp_b, 0);
    reset = 1'b1;
    xact("push11", OP_PUSH, 8'h11, 2, 0, -1, 0, 1);
    xact("push22", OP_PUSH, 8'h22, 2, 0, -1, 0, 2);
    xact("push33", OP_PUSH, 8'h33, 2, 0, -1, 0, 3);
    check("empty3", empty, 0);
    xact("peek", OP_PEEK, 8'h00, 3, 0, 8'h33, 0, 3);
    xact("pop2", OP_POP2, 8'h00, 4, 0, 8'h33, 8'h22, 1);
    xact("pop11", OP_POP, 8'h00, 3, 0, 8'h11, 0, 0);
    check("empty0", empty, 1);
    xact("pop_uf", OP_POP, 8'h00, 1, 1, 0, 0, 0);
    xact("peek_uf", OP_PEEK, 8'h00, 1, 1, 0, 0, 0);
    xact("push44", OP_PUSH, 8'h44, 2, 0, -1, 0, 1);
    xact("pop2_uf", OP_POP2, 8'h00, 1, 1, 0, 0, 1);
    xact("pop44", OP_POP, 8'h00, 3, 0, 8'h44, 0, 0);
    for (int i = 0; i < 16; i++) xact("fill", OP_PUSH, 8'hA0 + 8'(i), 2, 0, -1, 0, i + 1);
    check("full16", full, 1);
`ifdef STACK_WATERMARK_EN
    check("wm16", watermark, 16);
`endif
    xact("push_of", OP_PUSH, 8'hEE, 1, 1, 0, 0, 16);
    check("full_kept", full, 1);
    xact("pop_af", OP_POP, 8'h00, 3, 0, 8'hAF, 0, 15);
    check("full_drop", full, 0);
    @(negedge clk);
    clear = 1'b1;
    req_valid = 1'b1;
    req_op = OP_PUSH;
    req_data = 8'h99;
    #1 check("clr_ready", req_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    req_valid = 1'b0;
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_noacc", resp_valid, 0);
    @(negedge clk);
    check("clr_idle", resp_valid, 0);
    check("clr_count2", count, 0);
`ifdef STACK_WATERMARK_EN
    check("wm_clr", watermark, 0);
`endif
    for (int i = 0; i < 4; i++) xact("push4", OP_PUSH, 8'h60 + 8'(i), 2, 0, -1, 0, i + 1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = OP_POP;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_count", count, 0);
    check("abort_empty", empty, 1);
    check("abort_rvalid", resp_valid, 0);
    check("abort_a", resp_a, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    check("abort_count2", count, 0);
    xact("push55", OP_PUSH, 8'h55, 2, 0, -1, 0, 1);
    xact("pop55", OP_POP, 8'h00, 3, 0, 8'h55, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
